// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg
// Shared definitions for the ring-oscillator measurement controller:
// the FSM state encoding and the width of the RO counter value.
`timescale 1ns/10ps
package ro_meas_pkg;

    localparam int RO_COUNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/ro_count_sampler.sv
// ro_count_sampler
// Two-stage capture of the free-running RO count into the CLK domain.
// The count is only sampled while the oscillator is stopped, so the
// value is treated as settled once two consecutive samples agree.
// Ports:
//   CLK      - system clock
//   reset    - synchronous, active-high; clears both stages
//   ro_count - RO counter value, asynchronous to CLK
//   s2       - second-stage sample
//   stable   - first and second stage hold the same value
`timescale 1ns/10ps
module ro_count_sampler
    import ro_meas_pkg::*;
(
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [RO_COUNT_W-1:0] ro_count,
    output logic [RO_COUNT_W-1:0] s2,
    output logic                  stable
);

    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [RO_COUNT_W-1:0] s1_q;
    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [RO_COUNT_W-1:0] s2_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= ro_count;
            s2_q <= s1_q;
        end
    end

    assign s2     = s2_q;
    assign stable = (s1_q == s2_q);

endmodule

// File: rtl/ro_measure_ctrl.sv
// ro_measure_ctrl
// Runs one ring-oscillator measurement window: enables the RO for exactly
// WINDOW_CYCLES clocks, waits for the count to settle, then offers the
// captured 32-bit count over a valid/ready handshake.
// Ports:
//   CLK, reset      - system clock, synchronous active-high reset
//   start           - measurement request, accepted only when idle
//   busy            - high whenever a measurement is in progress or pending
//   ro_enable       - RO oscillator enable
//   ro_reset        - RO counter clear (level)
//   ro_count        - RO counter value (asynchronous)
//   result_data     - captured count
//   result_valid    - result available
//   result_ready    - consumer accepts the result
//   error           - count never settled; meaningful with result_valid
`timescale 1ns/10ps
module ro_measure_ctrl
    import ro_meas_pkg::*;
#(
    parameter int WINDOW_CYCLES  = 1024,
    parameter int SETTLE_CYCLES  = 4,
    parameter int STABLE_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  ro_enable,
    output logic                  ro_reset,
    input  logic [RO_COUNT_W-1:0] ro_count,
    output logic [RO_COUNT_W-1:0] result_data,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  error
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
    localparam int DRN_W = $clog2(STABLE_TIMEOUT + 1);

    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [DRN_W-1:0] DRN_SETTLE = DRN_W'(SETTLE_CYCLES);
    localparam logic [DRN_W-1:0] DRN_LAST   = DRN_W'(STABLE_TIMEOUT - 1);

    state_t                  state;
    logic [WIN_W-1:0]        win_cnt;
    logic [DRN_W-1:0]        drain_cnt;
    logic [RO_COUNT_W-1:0]   s2;
    logic                    stable;

    ro_count_sampler u_sampler (
        .CLK      (CLK),
        .reset    (reset),
        .ro_count (ro_count),
        .s2       (s2),
        .stable   (stable)
    );

    // All outputs are set on the transition into a state so they are
    // valid in the first cycle of that state.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            ro_enable    <= 1'b0;
            ro_reset     <= 1'b1;
            result_valid <= 1'b0;
            result_data  <= '0;
            error        <= 1'b0;
            win_cnt      <= '0;
            drain_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        ro_enable <= 1'b1;
                        ro_reset  <= 1'b0;
                        win_cnt   <= '0;
                    end
                end
                RUN: begin
                    // win_cnt holds the number of RUN cycles already completed.
                    if (win_cnt == WIN_LAST) begin
                        state     <= DRAIN;
                        ro_enable <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                DRAIN: begin
                    // A settled count wins over the timeout in the same cycle.
                    if (drain_cnt >= DRN_SETTLE && stable) begin
                        state        <= HOLD;
                        result_data  <= s2;
                        error        <= 1'b0;
                        result_valid <= 1'b1;
                    end else if (drain_cnt == DRN_LAST) begin
                        state        <= HOLD;
                        result_data  <= s2;
                        error        <= 1'b1;
                        result_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        ro_reset     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// tb_ro_measure_ctrl
// Bench for ro_measure_ctrl with a behavioural ring-oscillator model that
// counts every 0.37 CLK periods on its own timebase while enabled.
`timescale 1ns/10ps
module tb_ro_measure_ctrl;

    localparam int  W       = 8;
    localparam int  S       = 4;
    localparam int  T       = 64;
    localparam real CLK_P   = 10.0;
    localparam real RO_P    = 3.7;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        ro_enable;
    logic        ro_reset;
    logic [31:0] ro_count;
    logic [31:0] result_data;
    logic        result_valid;
    logic        result_ready;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_cnt;

    ro_measure_ctrl #(
        .WINDOW_CYCLES  (W),
        .SETTLE_CYCLES  (S),
        .STABLE_TIMEOUT (T)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .ro_enable    (ro_enable),
        .ro_reset     (ro_reset),
        .ro_count     (ro_count),
        .result_data  (result_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .error        (error)
    );

    always #5 CLK = ~CLK;

    // RO model: phase-offset so its ticks never coincide with CLK edges.
    logic [31:0] ro_cnt_model = '0;
    logic        jbit         = 1'b0;
    bit          jitter_en    = 1'b0;

    initial begin
        #0.13;
        forever begin
            if (ro_reset === 1'b1)       ro_cnt_model = '0;
            else if (ro_enable === 1'b1) ro_cnt_model = ro_cnt_model + 1;
            #3.7;
        end
    end

    // Non-settling mode: bit 0 flips once per CLK period while disabled.
    initial begin
        #2.3;
        forever begin
            if (ro_reset === 1'b1)                              jbit = 1'b0;
            else if (jitter_en && ro_enable === 1'b0)           jbit = ~jbit;
            #10;
        end
    end

    assign ro_count = ro_cnt_model ^ {31'b0, jbit};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max) begin
            if (result_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; result_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if ({busy, ro_enable, ro_reset, result_valid, error} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/en/rst/valid/err=%b required 00100",
                     {busy, ro_enable, ro_reset, result_valid, error});
        end
        n_checks++;
        if (result_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d required 0", result_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n; bit ok; int d; bit en_ok;
        repeat ($urandom_range(0, 5)) tick();
        pulse_start();
        en_ok = 1'b1;
        for (int i = 1; i <= W; i++) begin
            if (ro_enable !== 1'b1 || busy !== 1'b1) en_ok = 1'b0;
            tick();
        end
        n_checks++;
        if (!en_ok) begin
            n_fail++;
            $display("FAIL basic_enable_window: enable/busy dropped within cycles 1..%0d", W);
        end
        n_checks++;
        if (ro_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_enable_off: ro_enable=%b at cycle %0d required 0", ro_enable, W + 1);
        end
        wait_valid(200, n, ok);
        n_checks++;
        if (!ok || n != S + 1) begin
            n_fail++;
            $display("FAIL basic_latency: valid after %0d cycles (seen=%0d) required %0d", n, ok, S + 1);
        end
        d = int'(result_data) - exp_cnt;
        n_checks++;
        if (d < -1 || d > 1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: data=%0d err=%b required %0d+-1 err=0", result_data, error, exp_cnt);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: valid=%b busy=%b required 0 0", result_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int n; bit ok; logic [31:0] held_d; logic held_e; bit stable_ok; bit extra;
        pulse_start();
        wait_valid(200, n, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_valid: no result_valid within %0d cycles", n);
        end
        held_d = result_data;
        held_e = error;
        stable_ok = 1'b1;
        repeat (20) begin
            if (result_valid !== 1'b1 || result_data !== held_d || error !== held_e) stable_ok = 1'b0;
            tick();
        end
        n_checks++;
        if (!stable_ok || result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%0d err=%b required 1 %0d %b",
                     result_valid, result_data, error, held_d, held_e);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || ro_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_handshake: valid/busy/ro_reset=%b%b%b required 001",
                     result_valid, busy, ro_reset);
        end
        extra = 1'b0;
        repeat (10) begin
            if (result_valid !== 1'b0 || busy !== 1'b0) extra = 1'b1;
            tick();
        end
        n_checks++;
        if (extra) begin
            n_fail++;
            $display("FAIL bp_single: activity after handshake, valid=%b busy=%b required idle",
                     result_valid, busy);
        end
    endtask

    task automatic test_ignored_starts();
        int n; bit ok; int en_cycles; int later_en; int later_valid;
        start = 1'b1;
        tick();
        en_cycles = 0;
        for (int c = 1; c <= W + 5; c++) begin
            if (ro_enable === 1'b1) en_cycles++;
            start = (c == 3) || (c == W + 3);
            tick();
        end
        start = 1'b0;
        wait_valid(200, n, ok);
        n_checks++;
        if (!ok || en_cycles != W) begin
            n_fail++;
            $display("FAIL ign_run: enable cycles=%0d valid_seen=%0d required %0d 1", en_cycles, ok, W);
        end
        start = 1'b1;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        result_ready = 1'b0;
        later_en = 0;
        later_valid = 0;
        repeat (40) begin
            if (ro_enable === 1'b1) later_en++;
            if (result_valid === 1'b1) later_valid++;
            tick();
        end
        n_checks++;
        if (later_en != 0 || later_valid != 0) begin
            n_fail++;
            $display("FAIL ign_after: enable cycles=%0d valid cycles=%0d required 0 0", later_en, later_valid);
        end
    endtask

    task automatic test_timeout();
        int n; bit ok;
        jitter_en = 1'b1;
        pulse_start();
        repeat (W) tick();
        wait_valid(200, n, ok);
        n_checks++;
        if (!ok || n != T) begin
            n_fail++;
            $display("FAIL timeout_latency: valid at drain cycle %0d (seen=%0d) required %0d", n, ok, T);
        end
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_error: error=%b required 1", error);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        jitter_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int n; bit ok; int d; bit spurious;
        pulse_start();
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({ro_enable, ro_reset, busy, result_valid} !== 4'b0100) begin
            n_fail++;
            $display("FAIL midrun_reset: en/rst/busy/valid=%b required 0100",
                     {ro_enable, ro_reset, busy, result_valid});
        end
        spurious = 1'b0;
        repeat (30) begin
            if (result_valid !== 1'b0 || ro_enable !== 1'b0) spurious = 1'b1;
            tick();
        end
        n_checks++;
        if (spurious) begin
            n_fail++;
            $display("FAIL midrun_quiet: valid=%b enable=%b required 0 0 after abort", result_valid, ro_enable);
        end
        pulse_start();
        wait_valid(200, n, ok);
        d = int'(result_data) - exp_cnt;
        n_checks++;
        if (!ok || n != W + S + 1 || d < -1 || d > 1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_rerun: wait=%0d data=%0d err=%b required %0d %0d+-1 0",
                     n, result_data, error, W + S + 1, exp_cnt);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n; bit ok; int d; int mn; int mx; bit seq_ok;
        mn = 32'h7fffffff; mx = 0;
        seq_ok = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(200, n, ok);
            if (!ok) seq_ok = 1'b0;
            d = int'(result_data) - exp_cnt;
            n_checks++;
            if (d < -1 || d > 1 || error !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_result_%0d: data=%0d err=%b required %0d+-1 0", k, result_data, error, exp_cnt);
            end
            if (int'(result_data) < mn) mn = int'(result_data);
            if (int'(result_data) > mx) mx = int'(result_data);
            repeat ($urandom_range(0, 3)) tick();
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            if (busy !== 1'b0) seq_ok = 1'b0;
            tick();
            if (busy !== 1'b1 || ro_enable !== 1'b1) seq_ok = 1'b0;
        end
        start = 1'b0;
        n_checks++;
        if (!seq_ok || mx - mn > 1) begin
            n_fail++;
            $display("FAIL b2b_sequence: restart_ok=%b spread=%0d required 1 and <=1", seq_ok, mx - mn);
        end
        while (busy === 1'b1 && cyc < 90000) begin
            result_ready = 1'b1;
            tick();
        end
        result_ready = 1'b0;
        tick();
    endtask

    initial begin
        exp_cnt = int'($floor(W * CLK_P / RO_P));
        reset = 1'b1; start = 1'b0; result_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_starts();
        test_timeout();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_measure_ctrl.md
# ro_measure_ctrl

Controls one measurement window of a ring-oscillator counter block and reads back its count on the system clock. It drives the RO `enable` and counter `reset` inputs and gates the oscillator for an exact number of `CLK` cycles. It then waits for the RO-domain count to settle and hands a stable 32-bit result to the readout logic over a valid/ready handshake. It sits between the PUF/reference RO instances and the readout/transfer framework.

## Interface
- `WINDOW_CYCLES`, 1024: `CLK` cycles the oscillator is enabled per measurement; must be ≥ 1.
- `SETTLE_CYCLES`, 4: minimum `CLK` cycles after disable before sampling begins; must be ≥ 2.
- `STABLE_TIMEOUT`, 64: maximum drain cycles spent waiting for a stable count before `error` is flagged.
- `CLK` in 1: system clock; the only clock of this block.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a measurement; accepted only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `ro_enable` out 1: to RO `enable`.
- `ro_reset` out 1: to RO counter `reset`, as a level.
- `ro_count` in 32: RO counter value; asynchronous to `CLK`.
- `result_data` out 32: captured count.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.
- `error` out 1: count did not stabilise; qualified by `result_valid`.

## Operation
- States: IDLE, RUN, DRAIN, HOLD.
- IDLE:
  - `ro_enable`=0, `ro_reset`=1, so the counter is held cleared.
  - `start`=1 → RUN.
- RUN:
  - `ro_reset`=0, `ro_enable`=1.
  - A window counter of width clog2(WINDOW_CYCLES+1) counts RUN cycles.
  - After exactly WINDOW_CYCLES cycles in RUN → DRAIN.
- DRAIN:
  - `ro_enable`=0, `ro_reset`=0.
  - `ro_count` passes through two sampling registers, `s1` then `s2`, loaded every cycle.
  - A drain counter starts at 0 on entry.
  - Once drain counter ≥ SETTLE_CYCLES and `s1`==`s2`: capture `s2` into `result_data`, `error`=0 → HOLD.
  - If drain counter reaches STABLE_TIMEOUT first: capture `s2`, `error`=1 → HOLD.
- HOLD:
  - `result_valid`=1; `result_data` and `error` are held stable.
  - On `result_valid` && `result_ready` → IDLE.
- `start` outside IDLE is ignored and not queued. This includes `start` in the same cycle as the HOLD handshake.
- `result_ready` outside HOLD is ignored.
- Count arithmetic:
  - Wrap of the 32-bit RO count is the RO block's behaviour; it is not detected here.
  - The equality compare is a full 32-bit compare.

## Timing
- Reset values, one cycle after `reset` is sampled high: state IDLE, `busy`=0, `ro_enable`=0, `ro_reset`=1, `result_valid`=0, `result_data`=0, `error`=0.
- `reset` mid-operation aborts the measurement; the same reset values apply and no result is produced.
- With `start` high in cycle 0 (IDLE):
  - `ro_enable`=1 and `busy`=1 in cycles 1..WINDOW_CYCLES.
  - `ro_enable`=0 from cycle WINDOW_CYCLES+1.
- Earliest `result_valid` is cycle WINDOW_CYCLES+1+SETTLE_CYCLES+1.
- On handshake in cycle H:
  - `result_valid`=0, `busy`=0, `ro_reset`=1 in cycle H+1.
  - A new `start` is accepted from cycle H+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The `ro_count` sampling registers carry the ASYNC_REG/dont_touch attribute.

## Structure
- Package `ro_meas_pkg`:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, HOLD=2'd3);
  - RO count width constant (32).
- Sub-module `ro_count_sampler`:
  - two-stage register of `ro_count`;
  - outputs `s2` and `stable` (`s1`==`s2`);
  - has `CLK` and `reset`; reset values are 0.
- The top level contains the FSM, the window and drain counters, and the result registers.

## Test plan
- Behavioural RO model in the bench: while enabled, the count increments every 0.37 `CLK` period on an async clock.
- Basic, WINDOW_CYCLES=8: `start` pulse → `ro_enable` high exactly 8 cycles; `result_valid` with `result_data` within ±1 of 21 and `error`=0.
- Backpressure: hold `result_ready`=0 for 20 cycles → `result_valid`, `result_data` and `error` remain constant. Then `result_ready`=1 → single handshake, IDLE the next cycle, `ro_reset`=1.
- Ignored starts: pulse `start` in RUN, in DRAIN, and in the HOLD handshake cycle → exactly one result, no second `ro_enable` pulse.
- Non-settling count: model keeps toggling bit 0 after disable → `result_valid` at drain cycle 64, `error`=1.
- Reset mid-RUN at window cycle 3 → next cycle `ro_enable`=0, `ro_reset`=1, `busy`=0, no `result_valid`. A following `start` then yields a normal result.
- Back-to-back runs: `start` high continuously → consecutive measurements. Each result starts from a cleared counter: no accumulation, values within ±1 of each other.
